// File: rtl/mips_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mips_pkg : fetch-stage state encoding and shared constants. Rev 1.0
// ------------------------------------------------------------------
package mips_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_hold_buffer.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_hold_buffer : single-entry {instruction, pc} park register. Rev 1.0
// ------------------------------------------------------------------
module fetch_hold_buffer
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [31:0]        pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        pc_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [31:0]        pc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc_q    <= 32'h0;
    end else if (clear_i) begin
      instr_q <= NOP_INSTR;
      pc_q    <= 32'h0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// instruction_fetch_unit : PC owner and imem requester feeding IF/ID.
// Optional FETCH_STATS_EN adds fetch_count/flush_count ports.  Rev 1.0
// ------------------------------------------------------------------
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               Branch_Control,
  input  logic [31:0]        Branch_Target,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] Instruction_out,
  output logic [31:0]        PC_out,
  output logic               valid_out
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        flush_count
`endif
);

  fetch_state_e       state_q;
  logic [31:0]        pc_q;
  logic [31:0]        redirect_pc_q;
  logic               req_q;
  logic [INSTR_W-1:0] instr_q;
  logic [31:0]        pc_out_q;
  logic               valid_q;

  logic               slot_free;
  logic               hold_load;
  logic               hold_clear;
  logic [INSTR_W-1:0] hold_instr;
  logic [31:0]        hold_pc;

  always_comb begin
    slot_free  = !valid_q || enable;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    if (state_q == FETCH && imem_ready && !Branch_Control && !slot_free) begin
      hold_load = 1'b1;
    end
    if (state_q == HOLD && Branch_Control) begin
      hold_clear = 1'b1;
    end
  end

  fetch_hold_buffer u_hold (
    .clk     (clk),
    .reset   (reset),
    .load_i  (hold_load),
    .clear_i (hold_clear),
    .instr_i (imem_rdata),
    .pc_i    (pc_incr(pc_q)),
    .instr_o (hold_instr),
    .pc_o    (hold_pc)
  );

  // A free slot with nothing loaded becomes a bubble; later slot writes in
  // the case statement override this default.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      redirect_pc_q <= 32'h0;
      req_q         <= 1'b0;
      instr_q       <= NOP_INSTR;
      pc_out_q      <= 32'h0;
      valid_q       <= 1'b0;
    end else begin
      if (Branch_Control || slot_free) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
          if (Branch_Control) begin
            pc_q <= Branch_Target;
          end
        end
        FETCH: begin
          if (Branch_Control) begin
            if (imem_ready) begin
              pc_q <= Branch_Target;
            end else begin
              redirect_pc_q <= Branch_Target;
              state_q       <= DRAIN;
            end
          end else if (imem_ready) begin
            if (slot_free) begin
              instr_q  <= imem_rdata;
              pc_out_q <= pc_incr(pc_q);
              valid_q  <= 1'b1;
              pc_q     <= pc_incr(pc_q);
            end else begin
              state_q <= HOLD;
              req_q   <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (Branch_Control) begin
            pc_q    <= Branch_Target;
            state_q <= FETCH;
            req_q   <= 1'b1;
          end else if (enable) begin
            instr_q  <= hold_instr;
            pc_out_q <= hold_pc;
            valid_q  <= 1'b1;
            pc_q     <= pc_incr(pc_q);
            state_q  <= FETCH;
            req_q    <= 1'b1;
          end
        end
        DRAIN: begin
          // The outstanding response is wrong-path; the newest redirect wins.
          if (imem_ready) begin
            pc_q    <= Branch_Control ? Branch_Target : redirect_pc_q;
            state_q <= FETCH;
          end
          if (Branch_Control) begin
            redirect_pc_q <= Branch_Target;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req        = req_q;
  assign imem_addr       = pc_q;
  assign Instruction_out = instr_q;
  assign PC_out          = pc_out_q;
  assign valid_out       = valid_q;

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_q;
  logic [31:0] flush_count_q;
  logic        slot_load;

  always_comb begin
    slot_load = 1'b0;
    if (!Branch_Control) begin
      if (state_q == FETCH && imem_ready && slot_free) begin
        slot_load = 1'b1;
      end
      if (state_q == HOLD && enable) begin
        slot_load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count_q <= 32'h0;
      flush_count_q <= 32'h0;
    end else begin
      if (slot_load) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
      if (Branch_Control) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_instruction_fetch_unit : random fetch traffic scored against an
// architectural instruction-stream model.  Rev 1.0
// ------------------------------------------------------------------
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        Branch_Control;
  logic [31:0] Branch_Target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction_out;
  logic [31:0] PC_out;
  logic        valid_out;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] flush_count;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  int          consumed = 0;
  logic [31:0] exp_q[$];

  instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .Branch_Control  (Branch_Control),
    .Branch_Target   (Branch_Target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .Instruction_out (Instruction_out),
    .PC_out          (PC_out),
    .valid_out       (valid_out)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count     (fetch_count),
    .flush_count     (flush_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'hFFFF_FFFF;
    if (a == 32'h4) return 32'h5555_5555;
    return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; the memory answers the
  // address currently presented.  A redirect restarts the expected stream.
  task automatic drive(input logic en, input logic br, input logic [31:0] tgt, input logic rdy);
    enable         = en;
    Branch_Control = br;
    Branch_Target  = tgt;
    imem_ready     = imem_req & rdy;
    imem_rdata     = imem_ready ? mem_word(imem_addr) : $urandom;
    if (br && !reset) begin
      exp_q.delete();
      exp_q.push_back(tgt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: consumed instructions must follow the architectural stream,
  // transfers must be sequential except after redirects, and a pending
  // request must stay stable.
  logic [31:0] next_xfer;
  int          credit;
  logic        pend_vld;
  logic [31:0] pend_addr;
  logic        prev_free;
  logic        prev_br;
  logic [31:0] fetch_exp;
  logic [31:0] flush_exp;
  logic [31:0] sb_addr;

  always @(negedge clk) begin
    if (reset) begin
      next_xfer = RST_PC;
      credit    = 0;
      pend_vld  = 1'b0;
      pend_addr = 32'h0;
      prev_free = 1'b0;
      prev_br   = 1'b0;
      fetch_exp = 32'h0;
      flush_exp = 32'h0;
    end else begin
      if (pend_vld) begin
        check("req_held", {31'h0, imem_req}, 32'h1);
        check("addr_held", imem_addr, pend_addr);
      end
      pend_vld  = imem_req && !imem_ready;
      pend_addr = imem_addr;

      if (imem_req && imem_ready) begin
        if (credit == 0) check("xfer_seq", imem_addr, next_xfer);
        else credit--;
        next_xfer = imem_addr + 32'd4;
      end
      if (Branch_Control) credit = (imem_req && imem_ready) ? 1 : 2;

      if (prev_free && valid_out) fetch_exp = fetch_exp + 32'd1;
      if (prev_br) flush_exp = flush_exp + 32'd1;
      prev_free = !valid_out || enable;
      prev_br   = Branch_Control;

      if (valid_out && enable && !Branch_Control) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_empty: actual PC_out %h required no instruction", PC_out);
        end else begin
          sb_addr = exp_q.pop_front();
          check("slot_pc", PC_out, sb_addr + 32'd4);
          check("slot_instr", Instruction_out, mem_word(sb_addr));
          exp_q.push_back(sb_addr + 32'd4);
          consumed++;
        end
      end
    end
  end

  task automatic random_phase(input int cycles);
    logic [31:0] t;
    for (int i = 0; i < cycles; i++) begin
      t = (($urandom % 8) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      drive(($urandom % 4) != 0, ($urandom % 12) == 0, t, ($urandom % 3) != 0);
      tick();
    end
  endtask

  task automatic check_stats();
`ifdef FETCH_STATS_EN
    @(negedge clk);
    #1;
    check("fetch_count", fetch_count, fetch_exp);
    check("flush_count", flush_count, flush_exp);
`endif
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; Branch_Control = 1'b0; Branch_Target = 32'h0;
    imem_ready = 1'b0; imem_rdata = 32'h0;
    exp_q.push_back(RST_PC);
    repeat (3) tick();
    check("rst_valid", {31'h0, valid_out}, 32'h0);
    check("rst_instr", Instruction_out, 32'h0);
    check("rst_pc_out", PC_out, 32'h0);
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, RST_PC);

    // First valid after the 2nd edge, then a 3-cycle stall.
    reset = 1'b0;
    drive(1'b1, 1'b0, $urandom, 1'b1); tick();
    check("edge1_valid", {31'h0, valid_out}, 32'h0);
    check("edge1_req", {31'h0, imem_req}, 32'h1);
    drive(1'b1, 1'b0, $urandom, 1'b1); tick();
    check("edge2_valid", {31'h0, valid_out}, 32'h1);
    check("edge2_instr", Instruction_out, 32'hFFFF_FFFF);
    check("edge2_pc", PC_out, 32'h4);
    check("edge2_addr", imem_addr, 32'h4);
    repeat (3) begin
      drive(1'b0, 1'b0, $urandom, 1'b1); tick();
      check("stall_req", {31'h0, imem_req}, 32'h0);
      check("stall_instr", Instruction_out, 32'hFFFF_FFFF);
      check("stall_pc", PC_out, 32'h4);
    end
    drive(1'b1, 1'b0, $urandom, 1'b1); tick();
    check("unhold_instr", Instruction_out, 32'h5555_5555);
    check("unhold_pc", PC_out, 32'h8);
    check("unhold_addr", imem_addr, 32'h8);

    // Redirect with a completing transfer.
    drive(1'b1, 1'b1, 32'h100, 1'b1); tick();
    check("br_valid", {31'h0, valid_out}, 32'h0);
    check("br_addr", imem_addr, 32'h100);
    drive(1'b1, 1'b0, $urandom, 1'b1); tick();
    check("br_pc", PC_out, 32'h104);
    check("br_instr", Instruction_out, mem_word(32'h100));

    // Redirect during a wait: old request drains, then target.
    drive(1'b1, 1'b1, 32'h180, 1'b0); tick();
    check("drain_addr", imem_addr, 32'h104);
    check("drain_valid", {31'h0, valid_out}, 32'h0);
    repeat (2) begin
      drive(1'b1, 1'b0, $urandom, 1'b0); tick();
      check("drain_hold", imem_addr, 32'h104);
    end
    drive(1'b1, 1'b0, $urandom, 1'b1); tick();
    check("drain_done_addr", imem_addr, 32'h180);
    check("drain_done_valid", {31'h0, valid_out}, 32'h0);
    drive(1'b1, 1'b0, $urandom, 1'b1); tick();
    check("drain_tgt_pc", PC_out, 32'h184);

    // Two redirects while draining: the latest target wins.
    drive(1'b1, 1'b1, 32'h200, 1'b0); tick();
    drive(1'b1, 1'b1, 32'h300, 1'b0); tick();
    check("dbl_addr_old", imem_addr, 32'h184);
    drive(1'b1, 1'b0, $urandom, 1'b1); tick();
    check("dbl_addr_new", imem_addr, 32'h300);
    drive(1'b1, 1'b0, $urandom, 1'b1); tick();
    check("dbl_pc", PC_out, 32'h304);

    // PC wrap across 32'hFFFFFFFC.
    drive(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1); tick();
    drive(1'b1, 1'b0, $urandom, 1'b1); tick();
    check("wrap_pc0", PC_out, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, $urandom, 1'b1); tick();
    check("wrap_pc1", PC_out, 32'h0);
    drive(1'b1, 1'b0, $urandom, 1'b1); tick();
    check("wrap_pc2", PC_out, 32'h4);
    check("wrap_instr", Instruction_out, 32'hFFFF_FFFF);

    random_phase(3000);
    check("progress", {31'h0, consumed > 300}, 32'h1);
    check_stats();

    // Asynchronous reset in the middle of an active request.
    repeat (4) begin
      drive(1'b1, 1'b0, $urandom, 1'b1); tick();
    end
    check("pre_rst_valid", {31'h0, valid_out}, 32'h1);
    check("pre_rst_req", {31'h0, imem_req}, 32'h1);
    reset = 1'b1;
    #1;
    check("arst_req", {31'h0, imem_req}, 32'h0);
    check("arst_valid", {31'h0, valid_out}, 32'h0);
    check("arst_instr", Instruction_out, 32'h0);
    check("arst_pc", PC_out, 32'h0);
    check("arst_addr", imem_addr, RST_PC);
`ifdef FETCH_STATS_EN
    check("arst_fetch_cnt", fetch_count, 32'h0);
    check("arst_flush_cnt", flush_count, 32'h0);
`endif
    exp_q.delete();
    exp_q.push_back(RST_PC);
    tick(); tick();
    reset = 1'b0;
    consumed = 0;
    random_phase(1500);
    check("progress2", {31'h0, consumed > 150}, 32'h1);
    check_stats();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Producer side of the IF/ID pipeline register. It owns the program counter and issues requests to instruction memory over a req/ready handshake. Each returned word is presented as `Instruction_out`/`PC_out`/`valid_out` for IF/ID to sample on any edge where `enable`=1. It obeys the same hazard `enable` and `Branch_Control` redirect that IF/ID uses, so fetch and IF/ID never disagree about which instruction was consumed or flushed.

## Interface
- `RESET_PC`, default 32'h00000000: first fetch address after reset.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `enable`  in  1  1 = decode advances, so the presented instruction is consumed this edge; 0 = hazard stall.
- `Branch_Control`  in  1  redirect/flush; the presented instruction and any in-flight fetch are wrong-path.
- `Branch_Target`  in  32  redirect address; valid when `Branch_Control`=1.
- `imem_req`  out  1  instruction-memory request.
- `imem_addr`  out  32  request address; equals `pc`.
- `imem_ready`  in  1  transfer completes this cycle.
- `imem_rdata`  in  32  instruction word; valid when `imem_ready`=1.
- `Instruction_out`  out  32  instruction presented to IF/ID.
- `PC_out`  out  32  fetch address + 4 of the presented instruction.
- `valid_out`  out  1  presented instruction is real; 0 = bubble.

## Operation
- Slot = the `Instruction_out`/`PC_out`/`valid_out` registers. A slot is *free* this cycle if `valid_out`=0 or `enable`=1 (consumed at this edge).
- States:
  - IDLE: reset state, `imem_req`=0. Always moves to FETCH next edge.
  - FETCH: `imem_req`=1.
  - HOLD: `imem_req`=0; one fetched word is parked in the hold buffer.
  - DRAIN: `imem_req`=1; the response will be discarded.
- Handshake: `imem_req`/`imem_addr` are held stable until `imem_ready`=1; a started request is never withdrawn except by `reset`.
- FETCH, `imem_ready`=1, no redirect, slot free: slot ← {rdata, pc+4, 1}; pc ← pc+4; stay in FETCH.
- FETCH, `imem_ready`=1, slot not free: hold buffer ← {rdata, pc+4}; go to HOLD.
- HOLD, `enable`=1: slot ← hold buffer; pc ← pc+4; go to FETCH.
- Slot free but nothing loaded this edge: `valid_out` ← 0. Otherwise the slot holds its value while `enable`=0.
- Redirect has priority over stall and over everything else. `Branch_Control`=1 at an edge always sets `valid_out` ← 0.
  - FETCH with `imem_ready`=1: discard the word; pc ← `Branch_Target`; stay in FETCH.
  - FETCH with `imem_ready`=0: redirect_pc ← `Branch_Target`; go to DRAIN.
  - HOLD: discard the hold buffer; pc ← `Branch_Target`; go to FETCH.
  - DRAIN: redirect_pc ← new `Branch_Target` (latest redirect wins); on `imem_ready`=1 the response is discarded either way.
- DRAIN, `imem_ready`=1: discard the word; pc ← redirect_pc; go to FETCH.
- Arithmetic: pc+4 is 32-bit and wraps from 32'hFFFFFFFC to 0. The low two bits of `Branch_Target` pass through unchecked.

## Timing
- Reset values: `Instruction_out`=0, `PC_out`=0, `valid_out`=0, `imem_req`=0, `imem_addr`=`RESET_PC`, state=IDLE. Hold buffer and redirect_pc are 0.
- `reset` mid-transfer: `imem_req` drops asynchronously. The memory side must tolerate the abandoned request.
- Zero-wait memory with `enable`=1: first `valid_out`=1 appears after the 2nd rising edge following reset release. Throughput is one instruction per cycle thereafter.
- Redirect penalty with zero-wait memory: `Branch_Control` at edge k means the target word is in the slot after edge k+1. If the redirect lands in DRAIN, the penalty adds the remaining wait cycles of the old request.
- Stalls cost no refetch: at most one word is fetched ahead of the slot, and it is held in the hold buffer.

## Configuration
- `FETCH_STATS_EN` defined: adds two 32-bit wrapping output ports.
  - `fetch_count` increments on every slot load with valid=1.
  - `flush_count` increments on every edge with `Branch_Control`=1.
  - Both reset to 0.
- `FETCH_STATS_EN` undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `mips_pkg`:
  - the fetch state enum {IDLE, FETCH, HOLD, DRAIN};
  - `INSTR_W`=32, `PC_STEP`=4;
  - `NOP_INSTR`=32'h00000000;
  - the default `RESET_PC`.
- One natural sub-module: `fetch_hold_buffer`, a single-entry {instruction, pc} register with load/clear.

## Test plan
- Reset release, `imem_ready` tied to 1, `enable`=1, memory returns 32'hFFFFFFFF at address 0 → after the 2nd edge: `valid_out`=1, `Instruction_out`=32'hFFFFFFFF, `PC_out`=32'h00000004. Addresses then increment by 4 each cycle.
- Steady stream, then `enable`=0 for 3 cycles → slot holds 32'hFFFFFFFF / PC 4, state goes to HOLD, `imem_req`=0. On `enable`=1, the held word 32'h55555555 / `PC_out` 8 loads with no refetch.
- `Branch_Control`=1 with `Branch_Target`=32'h00000100 while `imem_ready`=1 → `valid_out`=0 the next cycle, `imem_addr`=32'h100. One cycle later `PC_out`=32'h104.
- Redirect while `imem_ready`=0 for 2 more cycles → state DRAIN, old address held. That response is not presented; fetch resumes at the target.
- Two redirects (targets 32'h200 then 32'h300) during DRAIN → fetch resumes at 32'h300.
- `reset` asserted mid-request → `imem_req`, `valid_out`, `Instruction_out`, `PC_out` go to 0 immediately. With `FETCH_STATS_EN` defined, the counters also clear to 0.
